// File: rtl/cflog_pkg.sv
// Shared definitions for the control-flow log sequencer.
// CFLOG_LOOP_COMPRESS_EN selects 3-word records and the repeat-count state.
package cflog_pkg;

  localparam logic [15:0] LOG_BASE_DEF = 16'h01B0;
  localparam logic [15:0] LOG_SIZE_DEF = 16'h0080;
  localparam logic [15:0] TCB_BASE_DEF = 16'hA000;
  localparam logic [15:0] TCB_SIZE_DEF = 16'h4000;

`ifdef CFLOG_LOOP_COMPRESS_EN
  localparam logic [15:0] RECORD_WORDS = 16'd3;
`else
  localparam logic [15:0] RECORD_WORDS = 16'd2;
`endif

  // Count words carry a set LSB so they never look like a halfword-aligned address.
  localparam logic        CNT_MARKER = 1'b1;
  localparam logic [14:0] CNT_SAT    = 15'h7FFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_SRC = 3'd1,
    ST_WR_DST = 3'd2,
`ifdef CFLOG_LOOP_COMPRESS_EN
    ST_WR_CNT = 3'd3,
`endif
    ST_FULL   = 3'd4,
    ST_CLEAR  = 3'd5
  } state_t;

  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] idx);
    return base + {idx[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/cflog_repeat_detect.sv
// Remembers the last logged pair and counts back-to-back repeats of it.
// Only built with CFLOG_LOOP_COMPRESS_EN.
`ifdef CFLOG_LOOP_COMPRESS_EN
module cflog_repeat_detect
  import cflog_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        new_rec,
  input  logic        rep_rec,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] ptr,
  output logic        match,
  output logic        first,
  output logic [15:0] cnt_word,
  output logic [15:0] slot
);

  logic [15:0] last_src;
  logic [15:0] last_dst;
  logic        last_vld;
  logic [14:0] cnt;
  logic [14:0] cnt_inc;

  assign match    = last_vld && (src == last_src) && (dst == last_dst);
  assign first    = (cnt == 15'd0);
  assign cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + 15'd1;
  assign cnt_word = {cnt_inc, CNT_MARKER};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      last_src <= 16'd0;
      last_dst <= 16'd0;
      last_vld <= 1'b0;
      cnt      <= 15'd0;
      slot     <= 16'd0;
    end else if (new_rec) begin
      last_src <= src;
      last_dst <= dst;
      last_vld <= 1'b1;
      cnt      <= 15'd0;
      // The count word lands just past the new record's dst word.
      slot     <= ptr + 16'd2;
    end else if (rep_rec) begin
      cnt <= cnt_inc;
    end
  end

endmodule
`endif

// File: rtl/cflog_controller.sv
// CF-Log write sequencer: logs branch pairs, raises full_irq and stalls the CPU until the TCB clears the log.
// Optional loop compression via CFLOG_LOOP_COMPRESS_EN.
module cflog_controller
  import cflog_pkg::*;
#(
  parameter logic [15:0] LOG_BASE = LOG_BASE_DEF,
  parameter logic [15:0] LOG_SIZE = LOG_SIZE_DEF,
  parameter logic [15:0] TCB_BASE = TCB_BASE_DEF,
  parameter logic [15:0] TCB_SIZE = TCB_SIZE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        entry_valid,
  input  logic [15:0] entry_src,
  input  logic [15:0] entry_dst,
  output logic        entry_ready,
  input  logic        tcb_ack,
  output logic        log_wr_en,
  output logic [15:0] log_wr_addr,
  output logic [15:0] log_wr_data,
  output logic [15:0] log_ptr,
  output logic        full_irq,
  output logic        cpu_stall
);

  state_t      state;
  logic [15:0] dst_q;
  logic        inside_tcb;
  logic        ack;
  logic        room;
  logic        accept;

  assign inside_tcb  = ({1'b0, pc} >= {1'b0, TCB_BASE}) &&
                       ({1'b0, pc} <  ({1'b0, TCB_BASE} + {1'b0, TCB_SIZE}));
  assign ack         = tcb_ack && inside_tcb;
  assign room        = (LOG_SIZE - log_ptr) >= RECORD_WORDS;
  assign entry_ready = !reset && (state == ST_IDLE) && !ack && room;
  assign accept      = entry_valid && entry_ready;

`ifdef CFLOG_LOOP_COMPRESS_EN
  logic        rd_match;
  logic        rd_first;
  logic [15:0] rd_cnt_word;
  logic [15:0] rd_slot;

  cflog_repeat_detect u_repeat (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == ST_CLEAR),
    .new_rec  (accept && !rd_match),
    .rep_rec  (accept && rd_match),
    .src      (entry_src),
    .dst      (entry_dst),
    .ptr      (log_ptr),
    .match    (rd_match),
    .first    (rd_first),
    .cnt_word (rd_cnt_word),
    .slot     (rd_slot)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      log_ptr     <= 16'd0;
      log_wr_en   <= 1'b0;
      log_wr_addr <= LOG_BASE;
      log_wr_data <= 16'd0;
      full_irq    <= 1'b0;
      cpu_stall   <= 1'b0;
      dst_q       <= 16'd0;
    end else begin
      log_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ack) begin
            state     <= ST_CLEAR;
            log_ptr   <= 16'd0;
            cpu_stall <= 1'b1;
          end else if (accept) begin
`ifdef CFLOG_LOOP_COMPRESS_EN
            if (rd_match) begin
              state       <= ST_WR_CNT;
              log_wr_en   <= 1'b1;
              log_wr_addr <= word_addr(LOG_BASE, rd_slot);
              log_wr_data <= rd_cnt_word;
              if (rd_first) log_ptr <= log_ptr + 16'd1;
            end else
`endif
            begin
              // The src word goes out on the strobe registered here; dst follows next cycle.
              state       <= ST_WR_SRC;
              log_wr_en   <= 1'b1;
              log_wr_addr <= word_addr(LOG_BASE, log_ptr);
              log_wr_data <= entry_src;
              log_ptr     <= log_ptr + 16'd1;
              dst_q       <= entry_dst;
            end
          end
        end
        ST_WR_SRC: begin
          state       <= ST_WR_DST;
          log_wr_en   <= 1'b1;
          log_wr_addr <= word_addr(LOG_BASE, log_ptr);
          log_wr_data <= dst_q;
          log_ptr     <= log_ptr + 16'd1;
        end
`ifdef CFLOG_LOOP_COMPRESS_EN
        ST_WR_CNT,
`endif
        ST_WR_DST: begin
          if ((LOG_SIZE - log_ptr) < RECORD_WORDS) begin
            state     <= ST_FULL;
            full_irq  <= 1'b1;
            cpu_stall <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FULL: begin
          if (ack) begin
            state    <= ST_CLEAR;
            log_ptr  <= 16'd0;
            full_irq <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state     <= ST_IDLE;
          cpu_stall <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
